// File: rtl/ssd_scan_arbiter.sv
// Two-client arbiter and scanner for an 8-digit multiplexed seven-segment display.
// The granted client owns a whole 8-slot frame; each slot is a dark gap followed by one lit digit.
module ssd_scan_arbiter #(
  parameter int unsigned TICK_DIV     = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic [7:0]  dp_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  input  logic [7:0]  dp_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        frame_done,
  output logic [7:0]  ssdAnode,
  output logic [6:0]  ssdCathode,
  output logic        ssdDp
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic          HAS_BLANK  = (BLANK_CYCLES > 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [3:0]    nib_q, nib_d;
  logic          pt_q, pt_d;
  logic          gnt_a_d, gnt_b_d, fd_d;
  logic [7:0]    anode_d;
  logic [6:0]    cath_d;
  logic          dpo_d;
  logic          slot_start;
  logic          any_req;

  // Hex glyph lookup, active-low {g..a}
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign any_req = req_a | req_b;

  // State register, slot bookkeeping and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dig_q      <= '0;
      nib_q      <= '0;
      pt_q       <= 1'b0;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      frame_done <= 1'b0;
      ssdAnode   <= 8'hFF;
      ssdCathode <= 7'h7F;
      ssdDp      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      nib_q      <= nib_d;
      pt_q       <= pt_d;
      gnt_a      <= gnt_a_d;
      gnt_b      <= gnt_b_d;
      frame_done <= fd_d;
      ssdAnode   <= anode_d;
      ssdCathode <= cath_d;
      ssdDp      <= dpo_d;
    end
  end

  // Next-state, arbitration at idle/frame boundary, slot sampling and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    nib_d      = nib_q;
    pt_d       = pt_q;
    gnt_a_d    = gnt_a;
    gnt_b_d    = gnt_b;
    fd_d       = 1'b0;
    slot_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        dig_d = 3'd0;
        if (any_req) begin
          gnt_b_d    = req_b;
          gnt_a_d    = ~req_b;
          slot_start = 1'b1;
        end else begin
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
        end
      end
      ST_BLANK, ST_DRIVE: begin
        if (cnt_q != SLOT_LAST) begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == ST_BLANK && cnt_q == BLANK_LAST) state_d = ST_DRIVE;
        end else if (dig_q != 3'd7) begin
          dig_d      = dig_q + 3'd1;
          slot_start = 1'b1;
        end else begin
          fd_d  = 1'b1;
          dig_d = 3'd0;
          if (any_req) begin
            gnt_b_d    = req_b;
            gnt_a_d    = ~req_b;
            slot_start = 1'b1;
          end else begin
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        cnt_d   = '0;
        dig_d   = 3'd0;
      end
    endcase

    // Capture the owner's nibble and dp once, at the edge that opens the slot
    if (slot_start) begin
      cnt_d   = '0;
      state_d = HAS_BLANK ? ST_BLANK : ST_DRIVE;
      nib_d   = gnt_b_d ? data_b[{dig_d, 2'b00} +: 4] : data_a[{dig_d, 2'b00} +: 4];
      pt_d    = gnt_b_d ? dp_b[dig_d] : dp_a[dig_d];
    end

    anode_d = (state_d == ST_DRIVE) ? ~(8'b1 << dig_d) : 8'hFF;
    cath_d  = (state_d == ST_DRIVE) ? seg_decode(nib_d) : 7'h7F;
    dpo_d   = (state_d == ST_DRIVE) ? ~pt_d : 1'b1;
  end

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// Bench for ssd_scan_arbiter: two instances (blank gap 2 and 0) against a frame-position model.
module tb_ssd_scan_arbiter;

  localparam int TD = 10;
  localparam int FR = 8 * TD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_a, req_b;
  logic [31:0] data_a, data_b;
  logic [7:0]  dp_a, dp_b;

  logic       ga [2];
  logic       gb [2];
  logic       fdo [2];
  logic [7:0] an [2];
  logic [6:0] ca [2];
  logic       dpo [2];

  ssd_scan_arbiter #(.TICK_DIV(TD), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .dp_a(dp_a),
    .req_b(req_b), .data_b(data_b), .dp_b(dp_b),
    .gnt_a(ga[0]), .gnt_b(gb[0]), .frame_done(fdo[0]),
    .ssdAnode(an[0]), .ssdCathode(ca[0]), .ssdDp(dpo[0])
  );

  ssd_scan_arbiter #(.TICK_DIV(TD), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .dp_a(dp_a),
    .req_b(req_b), .data_b(data_b), .dp_b(dp_b),
    .gnt_a(ga[1]), .gnt_b(gb[1]), .frame_done(fdo[1]),
    .ssdAnode(an[1]), .ssdCathode(ca[1]), .ssdDp(dpo[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: owner (0 none, 1 A, 2 B) and position within the 80-cycle frame
  int         own [2] = '{0, 0};
  int         pos [2] = '{0, 0};
  logic [3:0] mnib [2] = '{4'h0, 4'h0};
  logic       mdp [2] = '{1'b0, 1'b0};
  logic       mfd [2] = '{1'b0, 1'b0};

  // Model update on each clock edge, async clear on reset
  always @(posedge clk or negedge reset) begin
    logic [31:0] src;
    logic [7:0]  pts;
    int          d;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        own[i] = 0;
        pos[i] = 0;
        mfd[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mfd[i] = 1'b0;
        if (own[i] == 0 || pos[i] == FR - 1) begin
          if (own[i] != 0) mfd[i] = 1'b1;
          own[i] = req_b ? 2 : (req_a ? 1 : 0);
          pos[i] = 0;
        end else begin
          pos[i] = pos[i] + 1;
        end
        if (own[i] != 0 && (pos[i] % TD) == 0) begin
          d       = pos[i] / TD;
          src     = (own[i] == 2) ? data_b : data_a;
          pts     = (own[i] == 2) ? dp_b : dp_a;
          mnib[i] = 4'(src >> (4 * d));
          mdp[i]  = pts[d];
        end
      end
    end
  end

  // Compare every output of both instances against the model mid-cycle
  always @(negedge clk) begin
    logic [7:0] one8;
    logic [7:0] ea;
    logic [6:0] ec;
    logic       ed;
    int         blank;
    one8 = 8'h01;
    for (int i = 0; i < 2; i++) begin
      blank = (i == 0) ? 2 : 0;
      if (own[i] == 0 || (pos[i] % TD) < blank) begin
        ea = 8'hFF; ec = 7'h7F; ed = 1'b1;
      end else begin
        ea = ~(one8 << (pos[i] / TD));
        ec = glyph[mnib[i]];
        ed = ~mdp[i];
      end
      chk($sformatf("gnt_a[%0d]", i), 32'(ga[i]), 32'(own[i] == 1));
      chk($sformatf("gnt_b[%0d]", i), 32'(gb[i]), 32'(own[i] == 2));
      chk($sformatf("frame_done[%0d]", i), 32'(fdo[i]), 32'(mfd[i]));
      chk($sformatf("anode[%0d]", i), 32'(an[i]), 32'(ea));
      chk($sformatf("cathode[%0d]", i), 32'(ca[i]), 32'(ec));
      chk($sformatf("dp[%0d]", i), 32'(dpo[i]), 32'(ed));
      chk($sformatf("grant_excl[%0d]", i), 32'(ga[i] & gb[i]), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_anode[%0d]", tag, i), 32'(an[i]), 32'h0FF);
      chk($sformatf("%s_cath[%0d]", tag, i), 32'(ca[i]), 32'h07F);
      chk($sformatf("%s_dp[%0d]", tag, i), 32'(dpo[i]), 32'd1);
      chk($sformatf("%s_gnt[%0d]", tag, i), 32'({ga[i], gb[i]}), 32'd0);
      chk($sformatf("%s_fd[%0d]", tag, i), 32'(fdo[i]), 32'd0);
    end
  endtask

  // Directed scenarios with hand-computed literal expectations
  initial begin
    reset  = 1'b0;
    req_a  = 1'b1;
    req_b  = 1'b1;
    data_a = 32'h01234567;
    dp_a   = 8'h00;
    data_b = 32'hFEDCBA98;
    dp_b   = 8'h01;
    tick(3);
    chk_reset_vals("reset_hold");
    req_a = 1'b0;
    req_b = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(3);
    chk("idle_gnt_a", 32'(ga[0]), 32'd0);

    // Client A alone
    req_a = 1'b1;
    tick(1);
    chk("a_gnt_rise", 32'(ga[0]), 32'd1);
    chk("a_slot0_blank", 32'(an[0]), 32'h0FF);
    chk("a_slot0_noblank", 32'(an[1]), 32'h0FE);
    tick(1);
    chk("a_slot1_blank", 32'(an[0]), 32'h0FF);
    tick(1);
    chk("a_d0_anode", 32'(an[0]), 32'h0FE);
    chk("a_d0_glyph7", 32'(ca[0]), 32'(7'b1111000));
    tick(8);
    chk("a_d1_blank", 32'(an[0]), 32'h0FF);
    tick(2);
    chk("a_d1_anode", 32'(an[0]), 32'h0FD);
    chk("a_d1_glyph6", 32'(ca[0]), 32'(7'b0000010));
    tick(67);
    chk("a_fd_early", 32'(fdo[0]), 32'd0);
    tick(1);
    chk("a_fd_80", 32'(fdo[0]), 32'd1);
    chk("a_gnt_held", 32'(ga[0]), 32'd1);

    // Preemption: B requests during digit 3
    tick(30);
    req_b = 1'b1;
    tick(49);
    chk("pre_a_held", 32'(ga[0]), 32'd1);
    chk("pre_b_wait", 32'(gb[0]), 32'd0);
    tick(1);
    chk("pre_b_gnt", 32'(gb[0]), 32'd1);
    chk("pre_a_drop", 32'(ga[0]), 32'd0);
    chk("pre_fd", 32'(fdo[0]), 32'd1);
    tick(2);
    chk("b_d0_anode", 32'(an[0]), 32'h0FE);
    chk("b_d0_glyph8", 32'(ca[0]), 32'(7'b0000000));
    chk("b_d0_dp", 32'(dpo[0]), 32'd0);
    chk("b_d0_glyph8_nb", 32'(ca[1]), 32'(7'b0000000));
    data_b = 32'hF1234567;
    tick(3);
    chk("b_midslot_hold", 32'(ca[0]), 32'(7'b0000000));
    tick(7);
    chk("b_d1_newdata", 32'(ca[0]), 32'(7'b0000010));
    tick(60);
    chk("b_d7_anode", 32'(an[0]), 32'h07F);
    chk("b_d7_glyphF", 32'(ca[0]), 32'(7'b0001110));
    chk("b_d7_dp", 32'(dpo[0]), 32'd1);

    // Release: A takes over, then drops mid-frame
    req_b = 1'b0;
    tick(8);
    chk("rel_a_gnt", 32'(ga[0]), 32'd1);
    tick(40);
    req_a = 1'b0;
    tick(39);
    chk("rel_held", 32'(ga[0]), 32'd1);
    chk("rel_d7_glyph0", 32'(ca[0]), 32'(7'b1000000));
    tick(1);
    chk("rel_idle_gnt", 32'({ga[0], gb[0]}), 32'd0);
    chk("rel_idle_anode", 32'(an[0]), 32'h0FF);
    chk("rel_idle_fd", 32'(fdo[0]), 32'd1);
    tick(1);
    chk("rel_idle_fd_once", 32'(fdo[0]), 32'd0);
    tick(3);

    // Async reset during digit 5 DRIVE
    req_a = 1'b1;
    tick(1);
    tick(53);
    chk("rst_d5_anode", 32'(an[0]), 32'h0DF);
    #1 reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("restart_gnt", 32'(ga[0]), 32'd1);
    chk("restart_d0_nb", 32'(an[1]), 32'h0FE);
    tick(2);
    chk("restart_d0", 32'(an[0]), 32'h0FE);

    // Simultaneous requests from IDLE
    req_a = 1'b0;
    tick(78);
    chk("sim_idle", 32'({ga[0], gb[0]}), 32'd0);
    req_a = 1'b1;
    req_b = 1'b1;
    tick(1);
    chk("sim_b_wins", 32'(gb[0]), 32'd1);
    chk("sim_a_loses", 32'(ga[0]), 32'd0);
    tick(20);
    req_a = 1'b0;
    req_b = 1'b0;
    tick(70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
